// File: rtl/ps2_pkg.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// ps2_pkg : shared frame constants and FSM encoding for the PS/2 receiver
// Rev 1.0
//==============================================================================
package ps2_pkg;

   localparam int PS2_FRAME_BITS = 11;
   localparam int PS2_CNT_W      = $clog2(PS2_FRAME_BITS);

   typedef logic [PS2_CNT_W-1:0] bitcnt_t;

   localparam bitcnt_t PS2_PAR_IDX  = bitcnt_t'(9);
   localparam bitcnt_t PS2_STOP_IDX = bitcnt_t'(10);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RECV = 1'b1
   } ps2_state_t;

endpackage
`default_nettype wire

// File: rtl/ps2_fifo.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// ps2_fifo : first-word-fall-through sync FIFO; head word is zero when empty
// Rev 1.0
//==============================================================================
module ps2_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           pop_data,
   output logic                       valid,
   output logic                       full,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int c_aw    = $clog2(DEPTH);
   localparam int c_cnt_w = c_aw + 1;

   logic [WIDTH-1:0]   r_mem [DEPTH];
   logic [c_aw-1:0]    r_wptr;
   logic [c_aw-1:0]    r_rptr;
   logic [c_cnt_w-1:0] r_count;
   logic               w_wr;
   logic               w_rd;

   assign valid    = (r_count != '0);
   assign full     = (r_count == c_cnt_w'(DEPTH));
   assign w_rd     = pop && valid;
   // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted
   assign w_wr     = push && (!full || w_rd);
   assign pop_data = valid ? r_mem[r_rptr] : '0;
   assign count    = r_count;

   always_ff @(posedge clk) begin
      if (w_wr) begin
         r_mem[r_wptr] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_wr) begin
            r_wptr <= r_wptr + 1'b1;
         end
         if (w_rd) begin
            r_rptr <= r_rptr + 1'b1;
         end
         if (w_wr && !w_rd) begin
            r_count <= r_count + 1'b1;
         end else if (!w_wr && w_rd) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/ps2_kbd_rx.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// ps2_kbd_rx : PS/2 keyboard frame receiver feeding a scan-code FIFO
// Rev 1.0
//==============================================================================
module ps2_kbd_rx
   import ps2_pkg::*;
#(
   parameter int FIFO_DEPTH  = 8,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          ps2_clk,
   input  logic                          ps2_data,
   output logic [7:0]                    data,
   output logic                          valid,
   input  logic                          ready,
   output logic [$clog2(FIFO_DEPTH):0]   count,
   output logic                          overflow,
   input  logic                          ovf_clr,
   output logic                          frame_err
);

   localparam int c_wdog_w = $clog2(TIMEOUT_CYC + 1);

   logic [SYNC_STAGES-1:0] r_clk_sync;
   logic [SYNC_STAGES-1:0] r_dat_sync;
   logic                   r_clk_prev;
   logic                   w_fe;
   logic                   w_dat;

   ps2_state_t             r_state,  w_state_nxt;
   bitcnt_t                r_bitcnt, w_bitcnt_nxt;
   logic [7:0]             r_sh,     w_sh_nxt;
   logic                   r_par,    w_par_nxt;
   logic [c_wdog_w-1:0]    r_wdog,   w_wdog_nxt;
   logic                   w_good;
   logic                   w_bad;
   logic                   w_full;
   logic                   w_ovf_set;
   logic                   r_overflow;
   logic                   r_frame_err;

   // Sync chains idle high so reset never fakes a falling edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_clk_sync <= '1;
         r_dat_sync <= '1;
         r_clk_prev <= 1'b1;
      end else begin
         r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
         r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], ps2_data};
         r_clk_prev <= r_clk_sync[SYNC_STAGES-1];
      end
   end

   assign w_fe  = r_clk_prev & ~r_clk_sync[SYNC_STAGES-1];
   assign w_dat = r_dat_sync[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_bitcnt    <= '0;
         r_sh        <= '0;
         r_par       <= 1'b0;
         r_wdog      <= '0;
         r_overflow  <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_bitcnt    <= w_bitcnt_nxt;
         r_sh        <= w_sh_nxt;
         r_par       <= w_par_nxt;
         r_wdog      <= w_wdog_nxt;
         r_frame_err <= w_bad;
         if (w_ovf_set) begin
            r_overflow <= 1'b1;
         end else if (ovf_clr) begin
            r_overflow <= 1'b0;
         end
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_bitcnt_nxt = r_bitcnt;
      w_sh_nxt     = r_sh;
      w_par_nxt    = r_par;
      w_wdog_nxt   = r_wdog;
      w_good       = 1'b0;
      w_bad        = 1'b0;
      case (r_state)
         IDLE: begin
            w_wdog_nxt = '0;
            if (w_fe && !w_dat) begin
               w_state_nxt  = RECV;
               w_bitcnt_nxt = bitcnt_t'(1);
            end
         end
         RECV: begin
            if (w_fe) begin
               w_wdog_nxt = '0;
               if (r_bitcnt == PS2_STOP_IDX) begin
                  w_state_nxt  = IDLE;
                  w_bitcnt_nxt = '0;
                  if ((^{r_sh, r_par}) && w_dat) begin
                     w_good = 1'b1;
                  end else begin
                     w_bad = 1'b1;
                  end
               end else begin
                  w_bitcnt_nxt = r_bitcnt + 1'b1;
                  if (r_bitcnt == PS2_PAR_IDX) begin
                     w_par_nxt = w_dat;
                  end else begin
                     w_sh_nxt = {w_dat, r_sh[7:1]};
                  end
               end
            end else if (r_wdog == c_wdog_w'(TIMEOUT_CYC - 1)) begin
               // Stalled keyboard: abandon the partial frame silently
               w_state_nxt  = IDLE;
               w_bitcnt_nxt = '0;
               w_wdog_nxt   = '0;
            end else begin
               w_wdog_nxt = r_wdog + 1'b1;
            end
         end
         default: begin
            w_state_nxt  = IDLE;
            w_bitcnt_nxt = '0;
         end
      endcase
   end

   assign w_ovf_set = w_good && w_full && !(valid && ready);
   assign overflow  = r_overflow;
   assign frame_err = r_frame_err;

   ps2_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (w_good),
      .push_data (r_sh),
      .pop       (ready),
      .pop_data  (data),
      .valid     (valid),
      .full      (w_full),
      .count     (count)
   );

endmodule
`default_nettype wire
